pipe_ctrl_unit: RTL and testbench

- Pipelined successor of the single-cycle RV32I control path.
- Decodes in D using the team's existing main_decoder and alu_decoder. Carries the control bundle through D/E, E/M and M/W registers.
- Generates load-use stall, branch/jump flush and pc_src.
- Adds an APB bus-wait FSM that freezes the pipeline while a MEM-stage peripheral transfer is outstanding, with a timeout.

---
 rtl/pipe_ctrl_unit.sv | 258 +++++++++++++++++++++++++
 tb/tb_pipe_ctrl_unit.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_ctrl_unit.sv
// pipe_ctrl_unit: RV32I pipelined control path (D decode, D/E, E/M, M/W control registers, hazards, APB bus wait).
// Latency: decode is combinational in D; each control reaches E/M/W 1/2/3 cycles after D.
// Backpressure: load-use stalls F/D and bubbles E; an APB transfer stuck in M freezes F..M until PREADY or timeout.
// Ports: clk/rst (sync, active-high); opcode_d/funct_d decode inputs; cond_true_e branch result;
//   load_use_hz from the hazard unit; bus_ready = PREADY; *_e/*_m/*_w registered stage controls;
//   imm_src_d combinational; stall_f/stall_d/flush_d/flush_e/pc_src_e hazard outputs; bus_stall/bus_timeout.
// ALU control codes: ADD=0 SUB=1 AND=2 OR=3 XOR=4 SLT=5 SLTU=6 SLL=7 SRL=8 SRA=9.
module pipe_ctrl_unit #(
  parameter int HAS_BUS_FSM = 1,
  parameter int TIMEOUT     = 16,
  parameter int CNT_W       = 5
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [6:0] opcode_d,
  input  logic [4:0] funct_d,
  input  logic       cond_true_e,
  input  logic       load_use_hz,
  input  logic       bus_ready,
  output logic [2:0] imm_src_d,
  output logic [3:0] alu_control_e,
  output logic       alu_src_e,
  output logic       lui_en_e,
  output logic       pc_src_e,
  output logic       mem_write_m,
  output logic [1:0] mem_strobe_m,
  output logic       trans_en_m,
  output logic       store_done_m,
  output logic       reg_write_m,
  output logic       reg_write_w,
  output logic [1:0] result_src_w,
  output logic       stall_f,
  output logic       stall_d,
  output logic       flush_d,
  output logic       flush_e,
  output logic       bus_stall,
  output logic       bus_timeout
);

  localparam logic [6:0] OP_LOAD  = 7'b0000011;
  localparam logic [6:0] OP_STORE = 7'b0100011;
  localparam logic [6:0] OP_R     = 7'b0110011;
  localparam logic [6:0] OP_I     = 7'b0010011;
  localparam logic [6:0] OP_BR    = 7'b1100011;
  localparam logic [6:0] OP_JAL   = 7'b1101111;
  localparam logic [6:0] OP_JALR  = 7'b1100111;
  localparam logic [6:0] OP_LUI   = 7'b0110111;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] mem_strobe;
    logic       trans_en;
    logic       store_done;
    logic       jump;
    logic       branch;
    logic [3:0] alu_control;
    logic       alu_src;
    logic       lui_en;
  } de_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
    logic       mem_write;
    logic [1:0] mem_strobe;
    logic       trans_en;
    logic       store_done;
  } em_t;

  typedef struct packed {
    logic       reg_write;
    logic [1:0] result_src;
  } mw_t;

  typedef enum logic {BUS_IDLE = 1'b0, BUS_WAIT = 1'b1} bus_state_t;

  de_t              dec_c, de_d, de_q;
  em_t              em_d, em_q;
  mw_t              mw_d, mw_q;
  bus_state_t       state_d, state_q;
  logic [CNT_W-1:0] cnt_d, cnt_q;
  logic             timeout_d, timeout_q;
  logic [1:0]       alu_op_c;
  logic [2:0]       imm_src_c;
  logic             bus_stall_c, give_up_c, freeze_c, pc_src_c, flush_e_c;

  // Main decoder followed by ALU decoder, both purely combinational in D.
  always_comb begin
    dec_c     = '0;
    alu_op_c  = 2'b00;
    imm_src_c = 3'b000;
    case (opcode_d)
      OP_LOAD: begin
        dec_c.reg_write = 1'b1;  dec_c.result_src = 2'b01; dec_c.alu_src = 1'b1;
        dec_c.trans_en  = 1'b1;  dec_c.mem_strobe = funct_d[1:0];
      end
      OP_STORE: begin
        dec_c.mem_write  = 1'b1; dec_c.alu_src    = 1'b1; dec_c.trans_en = 1'b1;
        dec_c.store_done = 1'b1; dec_c.mem_strobe = funct_d[1:0];
        imm_src_c = 3'b001;
      end
      OP_R: begin
        dec_c.reg_write = 1'b1; alu_op_c = 2'b10;
      end
      OP_I: begin
        dec_c.reg_write = 1'b1; dec_c.alu_src = 1'b1; alu_op_c = 2'b10;
      end
      OP_BR: begin
        dec_c.branch = 1'b1; alu_op_c = 2'b01; imm_src_c = 3'b010;
      end
      OP_JAL: begin
        dec_c.reg_write = 1'b1; dec_c.result_src = 2'b10; dec_c.jump = 1'b1;
        imm_src_c = 3'b011;
      end
      OP_JALR: begin
        dec_c.reg_write = 1'b1; dec_c.result_src = 2'b10; dec_c.jump = 1'b1;
        dec_c.alu_src   = 1'b1;
      end
      OP_LUI: begin
        dec_c.reg_write = 1'b1; dec_c.alu_src = 1'b1; dec_c.lui_en = 1'b1;
        imm_src_c = 3'b100;
      end
      default: ;
    endcase

    case (alu_op_c)
      2'b00:   dec_c.alu_control = 4'd0;
      2'b01:   dec_c.alu_control = 4'd1;
      default: begin
        case (funct_d[2:0])
          // SUB only for R-type (opcode[5]=1); in I-type funct7[5] is an immediate bit.
          3'b000:  dec_c.alu_control = (funct_d[4] & funct_d[3]) ? 4'd1 : 4'd0;
          3'b001:  dec_c.alu_control = 4'd7;
          3'b010:  dec_c.alu_control = 4'd5;
          3'b011:  dec_c.alu_control = 4'd6;
          3'b100:  dec_c.alu_control = 4'd4;
          3'b101:  dec_c.alu_control = funct_d[4] ? 4'd9 : 4'd8;
          3'b110:  dec_c.alu_control = 4'd3;
          default: dec_c.alu_control = 4'd2;
        endcase
      end
    endcase
  end

  // Bus FSM: state register.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= BUS_IDLE;
      cnt_q     <= '0;
      timeout_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      timeout_q <= timeout_d;
    end
  end

  // Bus FSM: next state.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    timeout_d = timeout_q;
    if (HAS_BUS_FSM != 0) begin
      case (state_q)
        BUS_IDLE: begin
          if (em_q.trans_en && !bus_ready) begin
            state_d = BUS_WAIT;
            cnt_d   = CNT_W'(1);
          end
        end
        default: begin
          if (bus_ready || give_up_c) begin
            state_d = BUS_IDLE;
            cnt_d   = '0;
            if (!bus_ready) timeout_d = 1'b1;
          end else begin
            cnt_d = cnt_q + CNT_W'(1);
          end
        end
      endcase
    end else begin
      state_d   = BUS_IDLE;
      cnt_d     = '0;
      timeout_d = 1'b0;
    end
  end

  // Bus FSM: outputs. The stall drops in the same cycle PREADY is seen, so a
  // completing transfer moves on at that edge.
  always_comb begin
    bus_stall_c = 1'b0;
    give_up_c   = 1'b0;
    if (HAS_BUS_FSM != 0) begin
      bus_stall_c = ~bus_ready & ((state_q == BUS_WAIT) |
                                  ((state_q == BUS_IDLE) & em_q.trans_en));
      give_up_c   = (state_q == BUS_WAIT) & ~bus_ready & (cnt_q == CNT_W'(TIMEOUT));
    end
  end

  // Hazard resolution and next values of the stage registers. On the timeout
  // cycle bus_stall is still reported, but the pipeline advances so the
  // abandoned load leaves M with its register write squashed.
  always_comb begin
    freeze_c  = bus_stall_c & ~give_up_c;
    pc_src_c  = ~freeze_c & (de_q.jump | (de_q.branch & cond_true_e));
    flush_e_c = ~freeze_c & (pc_src_c | load_use_hz);

    de_d = dec_c;
    if (freeze_c)       de_d = de_q;
    else if (flush_e_c) de_d = '0;

    em_d.reg_write  = de_q.reg_write;
    em_d.result_src = de_q.result_src;
    em_d.mem_write  = de_q.mem_write;
    em_d.mem_strobe = de_q.mem_strobe;
    em_d.trans_en   = de_q.trans_en;
    em_d.store_done = de_q.store_done;
    if (freeze_c) em_d = em_q;

    mw_d.reg_write  = em_q.reg_write & ~give_up_c;
    mw_d.result_src = em_q.result_src;
    if (freeze_c) mw_d = '0;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      de_q <= '0;
      em_q <= '0;
      mw_q <= '0;
    end else begin
      de_q <= de_d;
      em_q <= em_d;
      mw_q <= mw_d;
    end
  end

  assign imm_src_d     = imm_src_c;
  assign alu_control_e = de_q.alu_control;
  assign alu_src_e     = de_q.alu_src;
  assign lui_en_e      = de_q.lui_en;
  assign pc_src_e      = pc_src_c;
  assign mem_write_m   = em_q.mem_write;
  assign mem_strobe_m  = em_q.mem_strobe;
  assign trans_en_m    = em_q.trans_en;
  assign store_done_m  = em_q.store_done;
  assign reg_write_m   = em_q.reg_write;
  assign reg_write_w   = mw_q.reg_write;
  assign result_src_w  = mw_q.result_src;
  assign stall_f       = freeze_c | load_use_hz;
  assign stall_d       = freeze_c | load_use_hz;
  assign flush_d       = pc_src_c;
  assign flush_e       = flush_e_c;
  assign bus_stall     = bus_stall_c;
  assign bus_timeout   = (HAS_BUS_FSM != 0) ? timeout_q : 1'b0;

endmodule

// File: tb/tb_pipe_ctrl_unit.sv
// tb_pipe_ctrl_unit: scoreboard bench for pipe_ctrl_unit.
// Stimulus process drives one instruction per cycle and pushes the expected outputs;
// a negedge monitor pops and compares every output.
module tb_pipe_ctrl_unit;
  localparam int TMO = 16;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic [6:0] opcode_d = '0;
  logic [4:0] funct_d = '0;
  logic       cond_true_e = 1'b0, load_use_hz = 1'b0, bus_ready = 1'b1;
  logic [2:0] imm_src_d;
  logic [3:0] alu_control_e;
  logic       alu_src_e, lui_en_e, pc_src_e, mem_write_m, trans_en_m, store_done_m;
  logic [1:0] mem_strobe_m, result_src_w;
  logic       reg_write_m, reg_write_w, stall_f, stall_d, flush_d, flush_e, bus_stall, bus_timeout;

  pipe_ctrl_unit #(.HAS_BUS_FSM(1), .TIMEOUT(TMO), .CNT_W(5)) dut (
    .clk(clk), .rst(rst), .opcode_d(opcode_d), .funct_d(funct_d),
    .cond_true_e(cond_true_e), .load_use_hz(load_use_hz), .bus_ready(bus_ready),
    .imm_src_d(imm_src_d), .alu_control_e(alu_control_e), .alu_src_e(alu_src_e),
    .lui_en_e(lui_en_e), .pc_src_e(pc_src_e), .mem_write_m(mem_write_m),
    .mem_strobe_m(mem_strobe_m), .trans_en_m(trans_en_m), .store_done_m(store_done_m),
    .reg_write_m(reg_write_m), .reg_write_w(reg_write_w), .result_src_w(result_src_w),
    .stall_f(stall_f), .stall_d(stall_d), .flush_d(flush_d), .flush_e(flush_e),
    .bus_stall(bus_stall), .bus_timeout(bus_timeout)
  );

  // Per-instruction reference: encoding plus the controls it must produce.
  typedef struct packed {
    logic [6:0] op; logic [4:0] fn; logic [2:0] imm;
    logic rw; logic [1:0] rs; logic mw; logic [1:0] strb; logic te; logic sd;
    logic jmp; logic br; logic [3:0] alu; logic asrc; logic lui;
  } ctl_t;

  // Kinds: 0 NOP,1 ADD,2 SUB,3 AND,4 OR,5 XOR,6 SLT,7 SRA,8 SRL,9 SLL,10 ADDI,
  // 11 SLTIU,12 LW,13 LB,14 SW,15 SH,16 BEQ,17 JAL,18 JALR,19 LUI
  function automatic ctl_t mk(input int k);
    ctl_t c;
    c = '0;
    case (k)
      1:  begin c.op = 7'h33; c.fn = 5'b01000; c.rw = 1; c.alu = 4'd0; end
      2:  begin c.op = 7'h33; c.fn = 5'b11000; c.rw = 1; c.alu = 4'd1; end
      3:  begin c.op = 7'h33; c.fn = 5'b01111; c.rw = 1; c.alu = 4'd2; end
      4:  begin c.op = 7'h33; c.fn = 5'b01110; c.rw = 1; c.alu = 4'd3; end
      5:  begin c.op = 7'h33; c.fn = 5'b01100; c.rw = 1; c.alu = 4'd4; end
      6:  begin c.op = 7'h33; c.fn = 5'b01010; c.rw = 1; c.alu = 4'd5; end
      7:  begin c.op = 7'h33; c.fn = 5'b11101; c.rw = 1; c.alu = 4'd9; end
      8:  begin c.op = 7'h33; c.fn = 5'b01101; c.rw = 1; c.alu = 4'd8; end
      9:  begin c.op = 7'h33; c.fn = 5'b01001; c.rw = 1; c.alu = 4'd7; end
      10: begin c.op = 7'h13; c.fn = 5'b10000; c.rw = 1; c.asrc = 1; c.alu = 4'd0; end
      11: begin c.op = 7'h13; c.fn = 5'b00011; c.rw = 1; c.asrc = 1; c.alu = 4'd6; end
      12: begin c.op = 7'h03; c.fn = 5'b00010; c.rw = 1; c.rs = 2'b01; c.asrc = 1; c.te = 1; c.strb = 2'b10; end
      13: begin c.op = 7'h03; c.fn = 5'b00000; c.rw = 1; c.rs = 2'b01; c.asrc = 1; c.te = 1; c.strb = 2'b00; end
      14: begin c.op = 7'h23; c.fn = 5'b01010; c.mw = 1; c.asrc = 1; c.te = 1; c.sd = 1; c.strb = 2'b10; c.imm = 3'b001; end
      15: begin c.op = 7'h23; c.fn = 5'b01001; c.mw = 1; c.asrc = 1; c.te = 1; c.sd = 1; c.strb = 2'b01; c.imm = 3'b001; end
      16: begin c.op = 7'h63; c.fn = 5'b01000; c.br = 1; c.imm = 3'b010; c.alu = 4'd1; end
      17: begin c.op = 7'h6f; c.fn = 5'b01000; c.rw = 1; c.rs = 2'b10; c.jmp = 1; c.imm = 3'b011; end
      18: begin c.op = 7'h67; c.fn = 5'b01000; c.rw = 1; c.rs = 2'b10; c.jmp = 1; c.asrc = 1; end
      19: begin c.op = 7'h37; c.fn = 5'b01000; c.rw = 1; c.asrc = 1; c.lui = 1; c.imm = 3'b100; end
      default: ;
    endcase
    return c;
  endfunction

  typedef struct {
    int imm, alu, asrc, lui, pc, mw, strb, te, sdn, rwm, rww, rsw;
    int stf, std, fld, fle, bs, bt;
    int run;
  } exp_t;

  exp_t q[$];

  // Model state: which instruction kind sits in each stage.
  int e_k = 0, m_k = 0, w_k = 0;
  bit w_sq = 0, tmo_flag = 0;
  int age = 0;
  bit x_stall_d = 0, x_flush_d = 0;

  task automatic step(input int dk, input bit cond, input bit luh, input bit rdy,
                      input bit r, input int run);
    ctl_t d, e, m, w;
    bit bst, give, frz, pc;
    exp_t x;
    @(posedge clk);
    #1;
    d = mk(dk);
    rst = r; opcode_d = d.op; funct_d = d.fn;
    cond_true_e = cond; load_use_hz = luh; bus_ready = rdy;
    if (r) begin
      e_k = 0; m_k = 0; w_k = 0; w_sq = 0; tmo_flag = 0; age = 0;
      x_stall_d = 0; x_flush_d = 0;
    end else begin
      e = mk(e_k); m = mk(m_k); w = mk(w_k);
      bst  = m.te && !rdy;            // transfer sitting in M and not yet accepted
      give = bst && (age == TMO);     // it has already waited TIMEOUT cycles
      frz  = bst && !give;
      pc   = !frz && (e.jmp || (e.br && cond));
      x.imm = d.imm; x.alu = e.alu; x.asrc = e.asrc; x.lui = e.lui; x.pc = pc;
      x.mw = m.mw; x.strb = m.strb; x.te = m.te; x.sdn = m.sd; x.rwm = m.rw;
      x.rww = w.rw && !w_sq; x.rsw = w.rs;
      x.stf = frz || luh; x.std = frz || luh; x.fld = pc; x.fle = !frz && (pc || luh);
      x.bs = bst; x.bt = tmo_flag; x.run = run;
      q.push_back(x);
      x_stall_d = x.std[0]; x_flush_d = x.fld[0];
      if (frz) begin
        w_k = 0; w_sq = 0; age = age + 1;
      end else begin
        w_k = m_k; w_sq = give; m_k = e_k;
        e_k = (pc || luh) ? 0 : dk;
        if (give) tmo_flag = 1;
        age = 0;
      end
    end
  endtask

  // Monitor / checker.
  int checks = 0, errors = 0;
  int run_len = 0, last_run = 0;

  task automatic chk(input string nm, input int act, input int exp_v);
    checks++;
    if (act != exp_v) begin
      errors++;
      $display("FAIL %s at %0t: got %0d expected %0d", nm, $time, act, exp_v);
    end
  endtask

  always @(negedge clk) begin
    exp_t x;
    if (q.size() > 0) begin
      x = q.pop_front();
      chk("imm_src_d", int'(imm_src_d), x.imm);
      chk("alu_control_e", int'(alu_control_e), x.alu);
      chk("alu_src_e", int'(alu_src_e), x.asrc);
      chk("lui_en_e", int'(lui_en_e), x.lui);
      chk("pc_src_e", int'(pc_src_e), x.pc);
      chk("mem_write_m", int'(mem_write_m), x.mw);
      chk("mem_strobe_m", int'(mem_strobe_m), x.strb);
      chk("trans_en_m", int'(trans_en_m), x.te);
      chk("store_done_m", int'(store_done_m), x.sdn);
      chk("reg_write_m", int'(reg_write_m), x.rwm);
      chk("reg_write_w", int'(reg_write_w), x.rww);
      chk("result_src_w", int'(result_src_w), x.rsw);
      chk("stall_f", int'(stall_f), x.stf);
      chk("stall_d", int'(stall_d), x.std);
      chk("flush_d", int'(flush_d), x.fld);
      chk("flush_e", int'(flush_e), x.fle);
      chk("bus_stall", int'(bus_stall), x.bs);
      chk("bus_timeout", int'(bus_timeout), x.bt);
      if (bus_stall) run_len++;
      else begin
        if (run_len != 0) last_run = run_len;
        run_len = 0;
      end
      if (x.run != 0) chk("bus_stall_run_length", last_run, x.run);
    end
  end

  initial begin
    int dk;
    // Reset
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 1, 0);
    step(0, 0, 0, 1, 0, 0);
    // Stream ADD, SW, LW, BEQ (not taken)
    step(1, 0, 0, 1, 0, 0);
    step(14, 0, 0, 1, 0, 0);
    step(12, 0, 0, 1, 0, 0);
    step(16, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0, 0);
    // Taken BEQ
    step(16, 0, 0, 1, 0, 0);
    step(1, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    // Load-use: LW then dependent ADD held one cycle
    step(12, 0, 0, 1, 0, 0);
    step(1, 0, 1, 1, 0, 0);
    step(1, 0, 0, 1, 0, 0);
    repeat (4) step(0, 0, 0, 1, 0, 0);
    // APB LW with 3 wait cycles
    step(12, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 3);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    // APB LW timing out
    step(12, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (20) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 1, 0, 17);
    step(1, 0, 0, 1, 0, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    // Taken BEQ in E during a bus stall
    step(12, 0, 0, 1, 0, 0);
    step(16, 0, 0, 1, 0, 0);
    repeat (3) step(0, 1, 0, 0, 0, 0);
    step(0, 1, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 3);
    repeat (2) step(0, 0, 0, 1, 0, 0);
    // Reset in the middle of a wait clears the sticky timeout flag
    step(13, 0, 0, 1, 0, 0);
    step(0, 0, 0, 1, 0, 0);
    repeat (5) step(0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 1, 0);
    repeat (3) step(0, 0, 0, 1, 0, 0);
    // Randomized traffic
    dk = 0;
    for (int i = 0; i < 600; i++) begin
      if (x_flush_d) dk = 0;
      else if (!x_stall_d) dk = int'($urandom_range(0, 19));
      step(dk, bit'($urandom_range(0, 1)), ($urandom_range(0, 99) < 15),
           ($urandom_range(0, 99) < 75), (i == 300), 0);
    end
    repeat (3) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
